ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Opposite direction of the existing keyboard receive path. Shares the ps2_clk/ps2_data inout pins with the receiver.
- Drives the pins open-drain. The top level ties each pin low when its *_oe output is 1, and releases it to Z otherwise.
- Implements the inhibit / request-to-send / device-clocked shift / ACK sequence, with a timeout watchdog.

---
 rtl/ps2_host_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device using
// the inhibit / request-to-send / device-clocked shift / ACK handshake.
// The pins are open-drain: *_oe = 1 pulls the line low; 0 releases it.
// Optional build macro: PS2_HOST_TX_RETRY_EN. When defined, a NACK or timeout
// triggers one silent restart from INHIBIT with the same byte.
// INHIBIT_CYCLES must be at least 2.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_tx_done,
  output logic       o_tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic [7:0]             r_byte;
  logic                   r_par;
  logic [3:0]             r_bit;
  logic [INH_W-1:0]       r_inh_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_ack;
  logic                   r_tx_ready;
  logic                   r_busy;
  logic                   r_clk_oe;
  logic                   r_data_oe;
  logic                   r_tx_done;
  logic                   r_tx_error;
`ifdef PS2_HOST_TX_RETRY_EN
  logic                   r_retried;
`endif

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;
  logic w_lines_idle;
  logic w_timeout;
  logic w_fail;

  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s     = r_data_sync[SYNC_STAGES-1];
  assign w_fall       = r_clk_prev & ~w_clk_s;
  assign w_lines_idle = w_clk_s & w_data_s;
  // Watchdog only runs while waiting on the device.
  assign w_timeout    = ((r_state == S_SHIFT) || (r_state == S_WAIT_IDLE)) &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // A timeout takes priority over any fall seen in the same cycle.
  assign w_fail       = w_timeout ||
                        ((r_state == S_WAIT_IDLE) && w_lines_idle && r_ack);

  assign o_tx_ready    = r_tx_ready;
  assign o_busy        = r_busy;
  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_tx_done     = r_tx_done;
  assign o_tx_error    = r_tx_error;

  // Pin synchronizers and previous-clock register for falling-edge detect; idle bus reads high.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk_in};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data_in};
      r_clk_prev  <= w_clk_s;
    end
  end

  // Transmit FSM with all outputs registered.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_par      <= 1'b0;
      r_bit      <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_ack      <= 1'b0;
      r_tx_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      r_retried  <= 1'b0;
`endif
    end else begin
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
      if (w_fail) begin
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_to_cnt  <= '0;
        r_bit     <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
        if (!r_retried) begin
          // Silent second attempt with the same latched byte.
          r_retried <= 1'b1;
          r_clk_oe  <= 1'b1;
          r_inh_cnt <= INH_W'(1);
          r_state   <= S_INHIBIT;
        end else begin
          r_tx_error <= 1'b1;
          r_tx_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
`else
        r_tx_error <= 1'b1;
        r_tx_ready <= 1'b1;
        r_busy     <= 1'b0;
        r_state    <= S_IDLE;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_tx_valid) begin
              r_byte     <= i_tx_data;
              r_par      <= ~^i_tx_data;
              r_clk_oe   <= 1'b1;
              // Starts at 1 so the RTS cycle completes the INHIBIT_CYCLES clock-low window.
              r_inh_cnt  <= INH_W'(1);
              r_tx_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
              r_retried  <= 1'b0;
`endif
            end
          end
          S_INHIBIT: begin
            if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
              r_data_oe <= 1'b1;
              r_state   <= S_RTS;
            end else begin
              r_inh_cnt <= r_inh_cnt + 1'b1;
            end
          end
          S_RTS: begin
            r_clk_oe <= 1'b0;
            r_bit    <= '0;
            r_to_cnt <= '0;
            r_state  <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_fall) begin
              r_to_cnt <= '0;
              r_bit    <= r_bit + 1'b1;
              if (r_bit < 4'd8)       r_data_oe <= ~r_byte[r_bit[2:0]];
              else if (r_bit == 4'd8) r_data_oe <= ~r_par;
              else if (r_bit == 4'd9) r_data_oe <= 1'b0;
              else begin
                r_ack   <= w_data_s;
                r_state <= S_WAIT_IDLE;
              end
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            // NACK is handled on the failure path, so idle here means ACK was 0.
            if (w_lines_idle) begin
              r_tx_done  <= 1'b1;
              r_tx_ready <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else if (w_fall) begin
              r_to_cnt <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host; sampled bits are compared with a frame built from the byte value.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, clk_oe, data_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       pin_clk, pin_data;

  assign pin_clk  = ~(clk_oe | dev_clk_low);
  assign pin_data = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
    .o_tx_ready(tx_ready), .i_ps2_clk_in(pin_clk), .i_ps2_data_in(pin_data),
    .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe), .o_busy(busy),
    .o_tx_done(tx_done), .o_tx_error(tx_error)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0, n_clkoe = 0, n_done = 0, n_err = 0;
  int s_clkoe = 0, s_done = 0, s_err = 0, t_fall = 0;
  logic [9:0] got_bits;
  logic       got_start;

  // Event counters sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (clk_oe)   n_clkoe++;
    if (tx_done)  n_done++;
    if (tx_error) n_err++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: 8 data bits LSB first, odd parity, stop bit 1.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    logic [9:0] v;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      v[i] = b[i];
      if (b[i]) ones++;
    end
    v[8] = ((ones % 2) == 0);
    v[9] = 1'b1;
    return v;
  endfunction

  task automatic snap();
    s_clkoe = n_clkoe; s_done = n_done; s_err = n_err;
  endtask

  task automatic accept(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_drop", 32'(tx_ready), 32'd0);
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  // Device side of one frame: waits for request-to-send, then clocks nfalls falls.
  task automatic run_frame(input logic [7:0] b, input int nfalls, input bit ack, input bit wait_end);
    int h, k;
    got_bits = '0;
    k = 0;
    while (!(!clk_oe && data_oe) && k < 200) begin @(negedge clk); k++; end
    check("rts_seen", 32'(k < 200), 32'd1);
    repeat (6) @(negedge clk);
    got_start = pin_data;
    for (int i = 1; i <= nfalls; i++) begin
      h = int'($urandom_range(12, 30));
      dev_clk_low = 1'b1;
      t_fall = cyc;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i == 11) begin
        k = 0;
        if (wait_end) begin
          while (!(tx_done || tx_error) && k < 300) begin
            @(negedge clk); k++;
            if (k == 3) dev_data_low = 1'b0;
          end
          check("end_seen", 32'(k < 300), 32'd1);
        end else begin
          repeat (3) @(negedge clk);
        end
        dev_data_low = 1'b0;
      end else begin
        repeat (h / 2) @(negedge clk);
        got_bits[i-1] = pin_data;
        if (i == 10 && !ack) dev_data_low = 1'b1;
        repeat (h - h / 2) @(negedge clk);
      end
    end
    if (nfalls == 11) begin
      check("start_bit", 32'(got_start), 32'd0);
      check("frame_bits", 32'(got_bits), 32'(frame_bits(b)));
    end
  endtask

  // Called on the cycle the done/error pulse is visible.
  task automatic end_checks(input int exp_done, input int exp_err, input bit chk_inh, input int inh_exp);
    check("end_ready", 32'(tx_ready), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_oe", 32'({clk_oe, data_oe}), 32'd0);
    @(negedge clk);
    check("done_cnt", 32'(n_done - s_done), 32'(exp_done));
    check("err_cnt", 32'(n_err - s_err), 32'(exp_err));
    check("pulse_1cyc", 32'({tx_done, tx_error}), 32'd0);
    if (chk_inh) check("inhibit_len", 32'(n_clkoe - s_clkoe), 32'(inh_exp));
  endtask

  task automatic do_frame(input logic [7:0] b);
    snap();
    accept(b);
    run_frame(b, 11, 1'b0, 1'b1);
    end_checks(1, 0, 1'b1, INH);
  endtask

  initial begin
    logic [7:0] rb;
    int k;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clk_oe", 32'(clk_oe), 32'd0);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_error), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed bytes, then random ones.
    do_frame(8'hED);
    do_frame(8'h01);
    do_frame(8'h00);
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom);
      do_frame(rb);
    end

`ifndef PS2_HOST_TX_RETRY_EN
    // NACK from the device.
    rb = 8'($urandom);
    snap();
    accept(rb);
    run_frame(rb, 11, 1'b1, 1'b1);
    end_checks(0, 1, 1'b1, INH);

    // Device stops after fall 4: error exactly TO cycles after the fall is detected.
    rb = 8'($urandom);
    snap();
    accept(rb);
    run_frame(rb, 4, 1'b0, 1'b0);
    k = 0;
    while (!tx_error && k < TO + 200) begin @(negedge clk); k++; end
    check("to_seen", 32'(k < TO + 200), 32'd1);
    check("to_latency", 32'(cyc - t_fall), 32'(TO + 3));
    end_checks(0, 1, 1'b1, INH);
`else
    // First attempt NACKed, retry ACKed.
    rb = 8'($urandom);
    snap();
    accept(rb);
    run_frame(rb, 11, 1'b1, 1'b0);
    check("retry_busy", 32'(busy), 32'd1);
    run_frame(rb, 11, 1'b0, 1'b1);
    end_checks(1, 0, 1'b1, 2 * INH);
`endif

    // Reset while bit 5 (a 0, so data is pulled low) is on the line.
    snap();
    accept(8'h1C);
    run_frame(8'h1C, 6, 1'b0, 1'b0);
    check("b5_driven", 32'(data_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_oe", 32'({clk_oe, data_oe}), 32'd0);
    check("mrst_ready", 32'(tx_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_pulse", 32'({tx_done, tx_error}), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_nopulse", 32'((n_done - s_done) + (n_err - s_err)), 32'd0);
    do_frame(8'hFF);

    // tx_valid held high while tx_data changes mid-frame.
    snap();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    check("hold_busy", 32'(busy), 32'd1);
    run_frame(8'hA5, 11, 1'b0, 1'b1);
    end_checks(1, 0, 1'b0, 0);
    tx_valid = 1'b0;
    check("hold_accept", 32'(tx_ready), 32'd0);
    snap();
    run_frame(8'h55, 11, 1'b0, 1'b1);
    end_checks(1, 0, 1'b1, INH - 1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
